// File: rtl/mod997_acc_if.sv
// Handshake bundle for mod997_accumulator.
// The input side carries partial residues: in_valid, in_ready, in_data and in_last.
// The output side carries frame results: out_valid, out_ready, out_data and out_beats.
// The slave modport is the accumulator's view of the bundle.
// The master modport is the view of the upstream producer and downstream consumer.
interface mod997_acc_if #(
    parameter int W = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_beats;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats
    );
endinterface

// File: rtl/mod997_accumulator.sv
// mod997_accumulator: running modular sum of a stream of W-bit residues.
// One fully reduced result is emitted per frame, and in_last closes the frame.
//   clk  : clock; all state changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : mod997_acc_if.slave
//          in_valid/in_ready/in_data/in_last   : one residue per accepted beat
//          out_valid/out_ready/out_data/out_beats : frame result plus its
//                                                   beat count (saturates at 15)
// The block is in ACC while accepting beats and in HOLD while a result is presented.
// in_ready depends only on the state, so out_ready never reaches it combinationally.
module mod997_accumulator #(
    parameter int MOD = 997,
    parameter int W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    mod997_acc_if.slave     bus
);
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Constants widened to the sum width.
    // acc + in_data is at most (MOD-1) + (2^W-1), which fits in W+1 bits.
    // Because 2*MOD > 2^W-1, two conditional subtractions always reduce the sum fully.
    localparam logic [W:0] MOD_X  = (W+1)'(MOD);
    localparam logic [W:0] MOD2_X = (W+1)'(2 * MOD);

    state_t       state_reg, state_next;
    logic [W-1:0] acc_reg, acc_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [W-1:0] out_data_reg, out_data_next;
    logic [3:0]   out_beats_reg, out_beats_next;
    logic         out_valid_reg, out_valid_next;

    logic [W:0]   sum;
    logic [W-1:0] reduced;
    logic [3:0]   cnt_inc;
    logic         accept;

    assign accept = bus.in_valid && (state_reg == ACC);

    // Reduction datapath for the beat presented this cycle.
    always_comb begin
        sum = {1'b0, acc_reg} + {1'b0, bus.in_data};
        if (sum >= MOD2_X) begin
            reduced = W'(sum - MOD2_X);
        end else if (sum >= MOD_X) begin
            reduced = W'(sum - MOD_X);
        end else begin
            reduced = W'(sum);
        end
        cnt_inc = (cnt_reg == 4'd15) ? 4'd15 : cnt_reg + 4'd1;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_data_next  = out_data_reg;
        out_beats_next = out_beats_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            ACC: begin
                if (accept) begin
                    if (bus.in_last) begin
                        // Close the frame and start the next one from zero.
                        out_data_next  = reduced;
                        out_beats_next = cnt_inc;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next = reduced;
                        cnt_next = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_valid_reg && bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_beats_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_data_reg  <= out_data_next;
            out_beats_reg <= out_beats_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready  = (state_reg == ACC);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_beats = out_beats_reg;
endmodule
